// File: rtl/spi_request_arbiter.sv
// rtl/spi_request_arbiter.sv - round-robin arbiter sharing one quick_spi master between clients
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES without end_of_transaction.
module spi_request_arbiter #(
  parameter int NUM_REQUESTERS      = 3,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [NUM_REQUESTERS-1:0]                    req,
  input  logic [NUM_REQUESTERS-1:0]                    req_operation,
  input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
  input  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]                    ack,
  output logic [NUM_REQUESTERS-1:0]                    done,
  output logic [INCOMING_DATA_WIDTH-1:0]               rd_data,
  output logic                                         timeout_err,
  output logic                                         busy,
  output logic                                         spi_start,
  output logic                                         spi_operation,
  output logic [NUMBER_OF_SLAVES-1:0]                  spi_slave,
  output logic [OUTGOING_DATA_WIDTH-1:0]               spi_outgoing_data,
  input  logic                                         spi_end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0]               spi_incoming_data
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_EOT,
    ST_COMPLETE
  } state_e;

  state_e                           state_q, state_d;
  logic [PTR_W-1:0]                 ptr_q, ptr_d;
  logic [PTR_W-1:0]                 grant_q, grant_d;
  logic [NUM_REQUESTERS-1:0]        ack_q, ack_d;
  logic [NUM_REQUESTERS-1:0]        done_q, done_d;
  logic [INCOMING_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                             spi_start_q, spi_start_d;
  logic                             spi_op_q, spi_op_d;
  logic [NUMBER_OF_SLAVES-1:0]      spi_slave_q, spi_slave_d;
  logic [OUTGOING_DATA_WIDTH-1:0]   spi_data_q, spi_data_d;

  logic                             scan_found;
  logic [PTR_W-1:0]                 scan_idx;
  int                               scan_cand;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]                 tmo_cnt_q, tmo_cnt_d;
  logic                             timeout_err_q, timeout_err_d;

  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign ack               = ack_q;
  assign done              = done_q;
  assign rd_data           = rd_data_q;
  assign busy              = (state_q != ST_IDLE);
  assign spi_start         = spi_start_q;
  assign spi_operation     = spi_op_q;
  assign spi_slave         = spi_slave_q;
  assign spi_outgoing_data = spi_data_q;

  // Round-robin scan: first requesting client at or after ptr, wrapping around
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    scan_cand  = 0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      scan_cand = (int'(ptr_q) + k) % NUM_REQUESTERS;
      if (!scan_found && req[scan_cand]) begin
        scan_found = 1'b1;
        scan_idx   = PTR_W'(scan_cand);
      end
    end
  end

  // Next-state and registered-output logic; command fields only move in IDLE
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    ack_d       = '0;
    done_d      = '0;
    rd_data_d   = rd_data_q;
    spi_start_d = 1'b0;
    spi_op_d    = spi_op_q;
    spi_slave_d = spi_slave_q;
    spi_data_d  = spi_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (scan_found) begin
          grant_d     = scan_idx;
          spi_op_d    = req_operation[scan_idx];
          spi_slave_d = req_slave[int'(scan_idx)*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
          spi_data_d  = req_data[int'(scan_idx)*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
          ack_d       = NUM_REQUESTERS'(1) << scan_idx;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // start becomes visible the cycle after ack, for exactly one cycle
        spi_start_d = 1'b1;
        state_d     = ST_WAIT_EOT;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif
      end

      ST_WAIT_EOT: begin
        // master clears incoming data after EOT, so capture it now
        if (spi_end_of_transaction) begin
          rd_data_d = spi_incoming_data;
          done_d    = NUM_REQUESTERS'(1) << grant_q;
          state_d   = ST_COMPLETE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          rd_data_d     = '0;
          done_d        = NUM_REQUESTERS'(1) << grant_q;
          timeout_err_d = 1'b1;
          state_d       = ST_COMPLETE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      ST_COMPLETE: begin
        // winner drops to lowest priority; this cycle also lets the master recover
        ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      rd_data_q   <= '0;
      spi_start_q <= 1'b0;
      spi_op_q    <= 1'b0;
      spi_slave_q <= '0;
      spi_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
      spi_start_q <= spi_start_d;
      spi_op_q    <= spi_op_d;
      spi_slave_q <= spi_slave_d;
      spi_data_q  <= spi_data_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Watchdog counter and its error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb/tb_spi_request_arbiter.sv - directed self-checking bench for spi_request_arbiter
module tb_spi_request_arbiter;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk;
  logic        reset_n;
  logic [2:0]  req;
  logic [2:0]  req_operation;
  logic [5:0]  req_slave;
  logic [47:0] req_data;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic [7:0]  rd_data;
  logic        timeout_err;
  logic        busy;
  logic        spi_start;
  logic        spi_operation;
  logic [1:0]  spi_slave;
  logic [15:0] spi_outgoing_data;
  logic        spi_end_of_transaction;
  logic [7:0]  spi_incoming_data;

  int n_checks;
  int n_pass;
  int start_cnt;

  spi_request_arbiter #(
    .NUM_REQUESTERS(3),
    .INCOMING_DATA_WIDTH(8),
    .OUTGOING_DATA_WIDTH(16),
    .NUMBER_OF_SLAVES(2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_operation(req_operation),
    .req_slave(req_slave),
    .req_data(req_data),
    .ack(ack),
    .done(done),
    .rd_data(rd_data),
    .timeout_err(timeout_err),
    .busy(busy),
    .spi_start(spi_start),
    .spi_operation(spi_operation),
    .spi_slave(spi_slave),
    .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction),
    .spi_incoming_data(spi_incoming_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (spi_start) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack != 3'b000) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_txn(input string tag, input int g, input logic op, input logic [1:0] sl,
                         input logic [15:0] wd, input logic [7:0] rv, input bit drop, input bit scramble);
    bit got;
    wait_ack(got);
    check({tag, "_ack"}, 32'(ack), 32'(1) << g);
    if (!got) return;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_nostart_at_ack"}, 32'(spi_start), 32'd0);
    if (drop) req = 3'b000;
    if (scramble) req_data[g*16 +: 16] = 16'hFFFF;
    @(negedge clk);
    check({tag, "_start"}, 32'(spi_start), 32'd1);
    check({tag, "_cmd"}, {13'd0, spi_operation, spi_slave, spi_outgoing_data}, {13'd0, op, sl, wd});
    @(negedge clk);
    check({tag, "_start_drop"}, 32'(spi_start), 32'd0);
    @(negedge clk);
    spi_incoming_data      = rv;
    spi_end_of_transaction = 1'b1;
    @(negedge clk);
    spi_end_of_transaction = 1'b0;
    spi_incoming_data      = 8'h00;
    check({tag, "_done"}, 32'(done), 32'(1) << g);
    check({tag, "_rd_data"}, 32'(rd_data), 32'(rv));
    check({tag, "_frozen"}, 32'(spi_outgoing_data), 32'(wd));
    check({tag, "_no_tmo"}, 32'(timeout_err), 32'd0);
    @(negedge clk);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit got;
    int s0;
    int n;
    n_checks  = 0;
    n_pass    = 0;
    start_cnt = 0;
    reset_n   = 1'b1;
    req       = 3'b000;
    // client2: write, slave 2, 1234; client1: read, slave 1, A55A; client0: read, slave 3, 0F0F
    req_operation = 3'b100;
    req_slave     = {2'd2, 2'd1, 2'd3};
    req_data      = {16'h1234, 16'hA55A, 16'h0F0F};
    spi_end_of_transaction = 1'b0;
    spi_incoming_data      = 8'h00;
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {7'd0, ack, done, rd_data, timeout_err, busy, spi_start, spi_operation},
          32'd0);
    check("reset_spi_cmd", {14'd0, spi_slave, spi_outgoing_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // single read from client 1
    req = 3'b010;
    run_txn("single_rd", 1, 1'b0, 2'd1, 16'hA55A, 8'hC3, 1'b1, 1'b0);

    // write from client 2 returns 0 into rd_data
    req = 3'b100;
    run_txn("write", 2, 1'b1, 2'd2, 16'h1234, 8'h00, 1'b1, 1'b0);

    // fairness with all requests held: 0,1,2,0
    s0  = start_cnt;
    req = 3'b111;
    run_txn("rr0", 0, 1'b0, 2'd3, 16'h0F0F, 8'h11, 1'b0, 1'b0);
    run_txn("rr1", 1, 1'b0, 2'd1, 16'hA55A, 8'h22, 1'b0, 1'b0);
    run_txn("rr2", 2, 1'b1, 2'd2, 16'h1234, 8'h00, 1'b0, 1'b0);
    run_txn("rr3", 0, 1'b0, 2'd3, 16'h0F0F, 8'h33, 1'b1, 1'b0);
    check("rr_start_count", 32'(start_cnt - s0), 32'd4);

    // pointer wrap after a grant to the last client
    req = 3'b100;
    run_txn("wrap_last", 2, 1'b1, 2'd2, 16'h1234, 8'h00, 1'b1, 1'b0);
    req = 3'b011;
    run_txn("wrap_g0", 0, 1'b0, 2'd3, 16'h0F0F, 8'h44, 1'b0, 1'b0);
    run_txn("wrap_g1", 1, 1'b0, 2'd1, 16'hA55A, 8'h55, 1'b1, 1'b0);

    // command stability: client data changes after ack
    req = 3'b001;
    run_txn("stable", 0, 1'b0, 2'd3, 16'h0F0F, 8'h66, 1'b1, 1'b1);
    req_data[15:0] = 16'h0F0F;

    // spurious EOT while idle is ignored
    @(negedge clk);
    spi_incoming_data      = 8'h77;
    spi_end_of_transaction = 1'b1;
    @(negedge clk);
    spi_end_of_transaction = 1'b0;
    spi_incoming_data      = 8'h00;
    check("spurious_done", 32'(done), 32'd0);
    check("spurious_rd_data", 32'(rd_data), 32'h66);
    check("spurious_busy", 32'(busy), 32'd0);

    // reset in the middle of WAIT_EOT
    req_data[31:16] = 16'hBEEF;
    req = 3'b010;
    wait_ack(got);
    check("mid_rst_ack", 32'(ack), 32'b010);
    @(negedge clk);
    check("mid_rst_start", 32'(spi_start), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {7'd0, ack, done, rd_data, timeout_err, busy, spi_start, spi_operation},
          32'd0);
    check("mid_rst_spi_cmd", {14'd0, spi_slave, spi_outgoing_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_txn("post_rst", 1, 1'b0, 2'd1, 16'hBEEF, 8'h99, 1'b1, 1'b0);

`ifdef SPI_ARB_TIMEOUT_EN
    // watchdog abort when EOT never comes
    req = 3'b001;
    wait_ack(got);
    check("tmo_ack", 32'(ack), 32'b001);
    req = 3'b000;
    @(negedge clk);
    check("tmo_start", 32'(spi_start), 32'd1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (done != 3'b000) break;
    end
    check("tmo_latency", 32'(n), 32'd16);
    check("tmo_done", 32'(done), 32'b001);
    check("tmo_err", 32'(timeout_err), 32'd1);
    check("tmo_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_err_clr", 32'(timeout_err), 32'd0);
`else
    n = 0;
    check("no_tmo_err", 32'(timeout_err), 32'(n));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_request_arbiter.md
Name: spi_request_arbiter

Overview:
- Shares one quick_spi master between NUM_REQUESTERS independent clients.
- Arbitrates with a round-robin pointer and latches the winner's command.
- Sequences the master's start/end_of_transaction handshake and returns the read data to the winner.
- Sits between client logic (register banks, sensor pollers) and the single quick_spi instance.

Parameters:
- NUM_REQUESTERS, 3, number of client ports (2..8).
- INCOMING_DATA_WIDTH, 8, read data width; must match the master.
- OUTGOING_DATA_WIDTH, 16, write data width; must match the master.
- NUMBER_OF_SLAVES, 2, width of the slave-select field; must match the master.
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only with SPI_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQUESTERS  level request per client
- req_operation  in  NUM_REQUESTERS  per-client operation, 0=READ 1=WRITE
- req_slave  in  NUM_REQUESTERS*NUMBER_OF_SLAVES  per-client slave field, client i at [i*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES]
- req_data  in  NUM_REQUESTERS*OUTGOING_DATA_WIDTH  per-client outgoing word, packed the same way
- ack  out  NUM_REQUESTERS  one-cycle pulse: command accepted
- done  out  NUM_REQUESTERS  one-cycle pulse: transaction finished, rd_data valid
- rd_data  out  INCOMING_DATA_WIDTH  read result, valid while done pulses, held until next completion
- timeout_err  out  1  one-cycle pulse with done on watchdog abort; tied 0 without macro
- busy  out  1  high in every state except IDLE
- spi_start  out  1  to master start_transaction
- spi_operation  out  1  to master operation
- spi_slave  out  NUMBER_OF_SLAVES  to master slave
- spi_outgoing_data  out  OUTGOING_DATA_WIDTH  to master outgoing_data
- spi_end_of_transaction  in  1  from master
- spi_incoming_data  in  INCOMING_DATA_WIDTH  from master

Behaviour:
- Reset (async, reset_n low):
  - State is IDLE and the pointer is 0.
  - All outputs are 0: ack, done, rd_data, timeout_err, busy, spi_start, spi_operation, spi_slave, spi_outgoing_data.
  - A reset during a transaction abandons it. No done is issued, and the master is reset by the same reset_n.
- FSM states: IDLE, ISSUE, WAIT_EOT, COMPLETE.
- IDLE:
  - Scan req starting at index ptr, wrapping modulo NUM_REQUESTERS. The first set bit wins and becomes grant.
  - Latch that client's operation, slave and data into the spi_* registers.
  - Pulse ack[grant] and go to ISSUE.
  - If req is all zero, remain in IDLE.
- ISSUE: spi_start=1 for exactly one cycle, then go to WAIT_EOT.
- WAIT_EOT:
  - spi_start=0. The spi_* command outputs stay frozen, because the master samples them throughout the transaction.
  - When spi_end_of_transaction=1, capture spi_incoming_data into rd_data in that same cycle (the master clears it the next cycle), then go to COMPLETE.
- COMPLETE:
  - Pulse done[grant]. rd_data is valid.
  - Set ptr to (grant+1) mod NUM_REQUESTERS.
  - Go to IDLE. This gives the master's one-cycle WAIT->IDLE recovery before the next start.
- Write operations: rd_data still updates with whatever the master returns (0 for writes).
- Latency: req seen in IDLE -> ack in the next cycle; spi_start one cycle after ack; done one cycle after end_of_transaction.
- Command sampling: req, req_operation, req_slave and req_data are sampled only in IDLE. Changes after ack are ignored for the current transaction.
- Dropped request: a req dropped before acceptance is never served.
- Held request: a client holding req after done is re-eligible, but at the lowest priority relative to the pointer.
- Simultaneous events:
  - Requests arriving while busy wait for the next IDLE.
  - A spurious spi_end_of_transaction outside WAIT_EOT is ignored.
- Fairness: with all req high continuously, the grant order is 0,1,2,0,...

Optional Feature:
- Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_EOT and increments each cycle in that state.
  - When it reaches TIMEOUT_CYCLES without end_of_transaction, go to COMPLETE.
  - rd_data is forced to 0, and done[grant] pulses together with timeout_err.
  - The pointer advances as normal.
- Undefined: no counter; WAIT_EOT waits indefinitely; timeout_err is constant 0.

Test Plan:
- Reset mid-WAIT_EOT: assert reset_n=0 -> all outputs 0 and busy=0 the same cycle. After release, req=3'b010 -> ack=3'b010.
- Single read: req[1]=1, operation=0, slave=1, data=16'hA55A -> ack[1], then one spi_start pulse with spi_slave=1, spi_outgoing_data=16'hA55A. Model master returns 8'hC3 with EOT -> done[1], rd_data=8'hC3 one cycle later.
- Round robin: req=3'b111 held for 4 transactions -> grants 0,1,2,0. Exactly one spi_start per transaction, none while busy.
- Pointer wrap: last grant 2, then req=3'b011 -> grant 0, then grant 1.
- Command stability: change req_data[0] to 16'hFFFF after ack[0] -> spi_outgoing_data keeps the original value until done.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, master never asserts EOT -> done and timeout_err pulse 16 cycles after entering WAIT_EOT, rd_data=0, arbiter back in IDLE.
